board_move_committer: RTL and testbench

- Owns the authoritative 8x8 chess board register and writes committed moves into it.
- Writer-side counterpart to the allowed-move generator, which only reads board state.
- Accepts one move per valid/ready handshake and checks only source ownership, destination occupancy and game-over state. Move-pattern legality is the move generator's responsibility.
- Applies capture and pawn promotion, toggles side to move, and publishes the flattened board back to the move generator and display.

---
 rtl/board_move_committer.sv | 208 ++++++++++++++++++++
 tb/tb_board_move_committer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/board_move_committer.sv
// board_move_committer
//   Owns the authoritative 8x8 chess board and commits moves into it. One move
//   is accepted per valid/ready handshake; only source ownership, destination
//   occupancy and game-over state are checked (move-pattern legality belongs
//   to the move generator). Applies capture and pawn promotion, toggles side
//   to move and publishes the board as a flat register vector.
//
//   Square code: bit0 occupied, bit1 colour (1 = black), bits4:2 piece type
//   (001 pawn, 010 knight, 011 bishop, 100 rook, 101 queen, 110 king).
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high; loads the start position
//   move_valid     move request present
//   move_ready     request can be accepted (IDLE only)
//   from_row/col   source square (row 0 = black back rank)
//   to_row/col     destination square
//   promo_type     requested promotion piece type
//   move_done      one-cycle completion pulse
//   move_status    00 ok, 01 bad source, 10 bad destination, 11 game over
//   captured_piece code removed from the destination, 0 if none
//   board_flat     square (r,c) at bits [(r*8+c)*5 +: 5]
//   side_to_move   0 white, 1 black
//   game_over      sticky, set when a king is captured
//   ply_count      committed moves, saturating at MAX_PLIES
module board_move_committer #(
  parameter int MAX_PLIES = 1023,
  localparam int PW = $clog2(MAX_PLIES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          move_valid,
  output logic          move_ready,
  input  logic [2:0]    from_row,
  input  logic [2:0]    from_col,
  input  logic [2:0]    to_row,
  input  logic [2:0]    to_col,
  input  logic [2:0]    promo_type,
  output logic          move_done,
  output logic [1:0]    move_status,
  output logic [4:0]    captured_piece,
  output logic [319:0]  board_flat,
  output logic          side_to_move,
  output logic          game_over,
  output logic [PW-1:0] ply_count
);

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, WRITE, RESP} state_t;

  localparam logic [2:0] T_PAWN  = 3'b001;
  localparam logic [2:0] T_QUEEN = 3'b101;
  localparam logic [2:0] T_KING  = 3'b110;

  state_t        state_reg;
  logic [4:0]    board_reg [64];
  logic [2:0]    from_row_reg, from_col_reg, to_row_reg, to_col_reg, promo_reg;
  logic [4:0]    src_code_reg, dst_code_reg, moved_code_reg;
  logic [1:0]    status_reg;
  logic          move_ready_reg, move_done_reg, side_reg, game_over_reg;
  logic [1:0]    move_status_reg;
  logic [4:0]    captured_reg;
  logic [PW-1:0] ply_reg;

  logic [5:0]    from_idx, to_idx;
  logic [1:0]    status_next;
  logic [4:0]    moved_code_next;
  logic          promote;
  logic [2:0]    promo_kind;

  // Start position for one square; the index is {row, col}.
  function automatic logic [4:0] init_square(input logic [5:0] idx);
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] back_type;
    row = idx[5:3];
    col = idx[2:0];
    case (col)
      3'd0, 3'd7: back_type = 3'b100;
      3'd1, 3'd6: back_type = 3'b010;
      3'd2, 3'd5: back_type = 3'b011;
      3'd3:       back_type = 3'b101;
      default:    back_type = 3'b110;
    endcase
    case (row)
      3'd0:    init_square = {back_type, 2'b11};
      3'd1:    init_square = {T_PAWN, 2'b11};
      3'd6:    init_square = {T_PAWN, 2'b01};
      3'd7:    init_square = {back_type, 2'b01};
      default: init_square = 5'b00000;
    endcase
  endfunction

  assign from_idx = {from_row_reg, from_col_reg};
  assign to_idx   = {to_row_reg, to_col_reg};

  // Status priority: game over, then source, then destination.
  always_comb begin
    status_next = 2'b00;
    if (game_over_reg)
      status_next = 2'b11;
    else if (!src_code_reg[0] || (src_code_reg[1] != side_reg))
      status_next = 2'b01;
    else if ((from_idx == to_idx) || (dst_code_reg[0] && (dst_code_reg[1] == side_reg)))
      status_next = 2'b10;
  end

  // A pawn reaching the far rank for its colour is promoted; unusable
  // promotion requests fall back to a queen.
  always_comb begin
    promote = (src_code_reg[4:2] == T_PAWN) &&
              ((!src_code_reg[1] && (to_row_reg == 3'd0)) ||
               ( src_code_reg[1] && (to_row_reg == 3'd7)));
    promo_kind = ((promo_reg >= 3'b010) && (promo_reg <= 3'b101)) ? promo_reg : T_QUEEN;
    moved_code_next = promote ? {promo_kind, src_code_reg[1:0]} : src_code_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      for (int i = 0; i < 64; i++)
        board_reg[i] <= init_square(6'(i));
      from_row_reg    <= '0;
      from_col_reg    <= '0;
      to_row_reg      <= '0;
      to_col_reg      <= '0;
      promo_reg       <= '0;
      src_code_reg    <= '0;
      dst_code_reg    <= '0;
      moved_code_reg  <= '0;
      status_reg      <= '0;
      move_ready_reg  <= 1'b1;
      move_done_reg   <= 1'b0;
      move_status_reg <= 2'b00;
      captured_reg    <= '0;
      side_reg        <= 1'b0;
      game_over_reg   <= 1'b0;
      ply_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (move_valid && move_ready_reg) begin
            from_row_reg   <= from_row;
            from_col_reg   <= from_col;
            to_row_reg     <= to_row;
            to_col_reg     <= to_col;
            promo_reg      <= promo_type;
            move_ready_reg <= 1'b0;
            state_reg      <= FETCH;
          end
        end
        FETCH: begin
          src_code_reg <= board_reg[from_idx];
          dst_code_reg <= board_reg[to_idx];
          state_reg    <= CHECK;
        end
        CHECK: begin
          status_reg     <= status_next;
          moved_code_reg <= moved_code_next;
          state_reg      <= WRITE;
        end
        WRITE: begin
          if (status_reg == 2'b00) begin
            // from != to is guaranteed for an accepted move
            board_reg[from_idx] <= 5'b00000;
            board_reg[to_idx]   <= moved_code_reg;
            captured_reg        <= dst_code_reg;
            side_reg            <= ~side_reg;
            if (ply_reg != PW'(MAX_PLIES))
              ply_reg <= ply_reg + 1'b1;
            if (dst_code_reg[0] && (dst_code_reg[4:2] == T_KING))
              game_over_reg <= 1'b1;
          end else begin
            captured_reg <= 5'b00000;
          end
          move_status_reg <= status_reg;
          move_done_reg   <= 1'b1;
          state_reg       <= RESP;
        end
        RESP: begin
          move_done_reg  <= 1'b0;
          move_ready_reg <= 1'b1;
          state_reg      <= IDLE;
        end
        default: begin
          move_done_reg  <= 1'b0;
          move_ready_reg <= 1'b1;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  // Publish the board straight from the square registers.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_flat
      assign board_flat[gi*5 +: 5] = board_reg[gi];
    end
  endgenerate

  assign move_ready     = move_ready_reg;
  assign move_done      = move_done_reg;
  assign move_status    = move_status_reg;
  assign captured_piece = captured_reg;
  assign side_to_move   = side_reg;
  assign game_over      = game_over_reg;
  assign ply_count      = ply_reg;

endmodule

// File: tb/tb_board_move_committer.sv
module tb_board_move_committer;

  logic         clk;
  logic         reset;
  logic         move_valid;
  logic         move_ready;
  logic [2:0]   from_row, from_col, to_row, to_col, promo_type;
  logic         move_done;
  logic [1:0]   move_status;
  logic [4:0]   captured_piece;
  logic [319:0] board_flat;
  logic         side_to_move;
  logic         game_over;
  logic [9:0]   ply_count;

  int checks = 0;
  int errors = 0;

  board_move_committer #(.MAX_PLIES(1023)) dut (
    .clk(clk), .reset(reset), .move_valid(move_valid), .move_ready(move_ready),
    .from_row(from_row), .from_col(from_col), .to_row(to_row), .to_col(to_col),
    .promo_type(promo_type), .move_done(move_done), .move_status(move_status),
    .captured_piece(captured_piece), .board_flat(board_flat),
    .side_to_move(side_to_move), .game_over(game_over), .ply_count(ply_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] fr, fc, tr, tc, pr;
    logic [1:0] st;
    logic [4:0] cap, from_code, to_code;
    logic       side;
    int         ply;
    logic       go;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input int fr, fc, tr, tc, pr, st, cap, fcode, tcode, side, ply, go);
    vec_t v;
    v.fr = 3'(fr); v.fc = 3'(fc); v.tr = 3'(tr); v.tc = 3'(tc); v.pr = 3'(pr);
    v.st = 2'(st); v.cap = 5'(cap); v.from_code = 5'(fcode); v.to_code = 5'(tcode);
    v.side = 1'(side); v.ply = ply; v.go = 1'(go);
    return v;
  endfunction

  function automatic logic [4:0] sq(input int r, input int c);
    return board_flat[(r*8+c)*5 +: 5];
  endfunction

  // Reference start position built from the piece layout.
  function automatic logic [319:0] start_board();
    logic [319:0] b;
    int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[(0*8+c)*5 +: 5] = {3'(back[c]), 2'b11};
      b[(1*8+c)*5 +: 5] = 5'b00111;
      b[(6*8+c)*5 +: 5] = 5'b00101;
      b[(7*8+c)*5 +: 5] = {3'(back[c]), 2'b01};
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_board(input string name, input logic [319:0] exp);
    checks++;
    if (board_flat !== exp) begin
      errors++;
      $display("FAIL %s board differs from start position", name);
    end
  endtask

  // Present a move, wait for the accept edge, then count cycles to move_done.
  task automatic do_move(input logic [2:0] fr, fc, tr, tc, pr, output int lat);
    int n;
    @(negedge clk);
    from_row = fr; from_col = fc; to_row = tr; to_col = tc; promo_type = pr;
    move_valid = 1'b1;
    n = 0;
    while (!move_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(move_ready), 32'd1);
    @(posedge clk);
    #1 move_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (move_done) break;
    end
  endtask

  initial begin
    int lat;
    int done_cnt;
    logic done_seen;

    vecs[0]  = mk(6,4,4,4,0, 0, 'h00, 'h00, 'h05, 1, 1, 0); // e2-e4
    vecs[1]  = mk(6,3,4,3,0, 1, 'h00, 'h05, 'h00, 1, 1, 0); // white moves on black's turn
    vecs[2]  = mk(0,0,1,0,0, 2, 'h00, 'h13, 'h07, 1, 1, 0); // onto own pawn
    vecs[3]  = mk(1,0,1,0,0, 2, 'h00, 'h07, 'h07, 1, 1, 0); // from == to
    vecs[4]  = mk(1,7,2,7,0, 0, 'h00, 'h00, 'h07, 0, 2, 0);
    vecs[5]  = mk(6,0,0,0,2, 0, 'h13, 'h00, 'h09, 1, 3, 0); // promote to knight
    vecs[6]  = mk(1,6,2,6,0, 0, 'h00, 'h00, 'h07, 0, 4, 0);
    vecs[7]  = mk(6,1,0,1,6, 0, 'h0B, 'h00, 'h15, 1, 5, 0); // bad promo -> queen
    vecs[8]  = mk(1,0,7,0,0, 0, 'h11, 'h00, 'h17, 0, 6, 0); // black promotion
    vecs[9]  = mk(3,3,2,3,0, 1, 'h00, 'h00, 'h00, 0, 6, 0); // empty source
    vecs[10] = mk(7,3,0,4,0, 0, 'h1B, 'h00, 'h15, 1, 7, 1); // queen takes king
    vecs[11] = mk(1,1,2,1,0, 3, 'h00, 'h07, 'h00, 1, 7, 1); // after game over

    reset = 1'b1; move_valid = 1'b0;
    from_row = 0; from_col = 0; to_row = 0; to_col = 0; promo_type = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);

    chk("rst_sq74", 32'(sq(7,4)), 32'h19);
    chk("rst_sq03", 32'(sq(0,3)), 32'h17);
    chk("rst_sq60", 32'(sq(6,0)), 32'h05);
    chk("rst_sq33", 32'(sq(3,3)), 32'h00);
    chk_board("rst_board", start_board());
    chk("rst_side", 32'(side_to_move), 32'd0);
    chk("rst_ply", 32'(ply_count), 32'd0);
    chk("rst_ready", 32'(move_ready), 32'd1);
    chk("rst_done", 32'(move_done), 32'd0);
    chk("rst_status", 32'(move_status), 32'd0);
    chk("rst_cap", 32'(captured_piece), 32'd0);
    chk("rst_go", 32'(game_over), 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_move(vecs[i].fr, vecs[i].fc, vecs[i].tr, vecs[i].tc, vecs[i].pr, lat);
      $display("move %0d (%0d,%0d)->(%0d,%0d) promo=%0d lat=%0d status=%b cap=%b side=%0d ply=%0d go=%0d",
               i, vecs[i].fr, vecs[i].fc, vecs[i].tr, vecs[i].tc, vecs[i].pr, lat,
               move_status, captured_piece, side_to_move, ply_count, game_over);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("v%0d_status", i), 32'(move_status), 32'(vecs[i].st));
      chk($sformatf("v%0d_captured", i), 32'(captured_piece), 32'(vecs[i].cap));
      chk($sformatf("v%0d_from_sq", i), 32'(sq(vecs[i].fr, vecs[i].fc)), 32'(vecs[i].from_code));
      chk($sformatf("v%0d_to_sq", i), 32'(sq(vecs[i].tr, vecs[i].tc)), 32'(vecs[i].to_code));
      chk($sformatf("v%0d_side", i), 32'(side_to_move), 32'(vecs[i].side));
      chk($sformatf("v%0d_ply", i), 32'(ply_count), 32'(vecs[i].ply));
      chk($sformatf("v%0d_game_over", i), 32'(game_over), 32'(vecs[i].go));
      @(negedge clk);
      chk($sformatf("v%0d_done_one_cycle", i), 32'(move_done), 32'd0);
    end

    // Reset while the move is in CHECK: no pulse, start position restored.
    @(negedge clk);
    from_row = 6; from_col = 4; to_row = 4; to_col = 4; promo_type = 0;
    move_valid = 1'b1;
    @(posedge clk);
    #1 move_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    done_seen = 1'b0;
    @(negedge clk) done_seen = done_seen | move_done;
    @(negedge clk) done_seen = done_seen | move_done;
    reset = 1'b0;
    @(negedge clk);
    $display("reset-abort: ready=%0d side=%0d ply=%0d go=%0d", move_ready, side_to_move, ply_count, game_over);
    chk("abort_ready", 32'(move_ready), 32'd1);
    chk_board("abort_board", start_board());
    chk("abort_side", 32'(side_to_move), 32'd0);
    chk("abort_ply", 32'(ply_count), 32'd0);
    chk("abort_go", 32'(game_over), 32'd0);
    repeat (6) @(negedge clk) done_seen = done_seen | move_done;
    chk("abort_no_done", 32'(done_seen), 32'd0);

    // move_valid held high across the whole transaction: one acceptance only.
    @(negedge clk);
    from_row = 6; from_col = 4; to_row = 4; to_col = 4; promo_type = 0;
    move_valid = 1'b1;
    @(posedge clk);
    done_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (move_done) done_cnt++;
      if (k < 4) chk($sformatf("hold_ready_c%0d", k), 32'(move_ready), 32'd0);
    end
    chk("hold_done_at4", 32'(move_done), 32'd1);
    chk("hold_status", 32'(move_status), 32'd0);
    move_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (move_done) done_cnt++;
    end
    $display("held-valid: done_pulses=%0d ply=%0d side=%0d", done_cnt, ply_count, side_to_move);
    chk("hold_single_done", 32'(done_cnt), 32'd1);
    chk("hold_ply", 32'(ply_count), 32'd1);
    chk("hold_side", 32'(side_to_move), 32'd1);
    chk("hold_sq44", 32'(sq(4,4)), 32'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
